// File: rtl/meas_pkg.sv
// Shared definitions for the measurement core: default widths, timeout
// budget and the duty-cycle meter state type.
package meas_pkg;

    localparam int unsigned MEAS_CNT_W          = 32;
    localparam int unsigned MEAS_TIMEOUT_CYCLES = 400000000;

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } dc_state_t;

endpackage

// File: rtl/duty_cycle_meter_if.sv
// Measured-signal input and count-buffer outputs of the duty-cycle meter.
// The slave modport is the meter; the master modport is the signal source and telemetry side.
interface duty_cycle_meter_if #(
    parameter int unsigned CNT_W = meas_pkg::MEAS_CNT_W
);
    logic             sig_in;
    logic [CNT_W-1:0] sig_in_high_cnt_buf;
    logic [CNT_W-1:0] sig_in_low_cnt_buf;
    logic             meas_valid;
    logic             sig_timeout;

    modport master (
        output sig_in,
        input  sig_in_high_cnt_buf,
        input  sig_in_low_cnt_buf,
        input  meas_valid,
        input  sig_timeout
    );

    modport slave (
        input  sig_in,
        output sig_in_high_cnt_buf,
        output sig_in_low_cnt_buf,
        output meas_valid,
        output sig_timeout
    );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, followed by one more
// flop so that single-cycle rise/fall strobes can be derived.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_dly_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            s_dly_q <= s;
        end
    end

    assign rise_o = s & ~s_dly_q;
    assign fall_o = ~s & s_dly_q;

endmodule

// File: rtl/duty_cycle_meter.sv
// Measures the high and low run lengths (sys_clk cycles) of the last complete
// period of sig_in, low phase reported alongside the preceding high phase.
module duty_cycle_meter
    import meas_pkg::*;
#(
    parameter int unsigned CNT_W          = MEAS_CNT_W,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = MEAS_TIMEOUT_CYCLES
) (
    input logic               sys_clk,
    input logic               rst_n,
    duty_cycle_meter_if.slave bus
);

    localparam int unsigned       IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic rise;
    logic fall;
    logic any_edge;
    logic expire;

    dc_state_t   state_q, state_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  hi_hold_q, hi_hold_d;
    logic [CNT_W-1:0]  high_buf_q, high_buf_d;
    logic [CNT_W-1:0]  low_buf_q, low_buf_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_i (sys_clk),
        .rst_i (rst_n),
        .d_i   (bus.sig_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    assign any_edge = rise | fall;
    // An edge arriving on the expiry cycle cancels the timeout.
    assign expire   = (idle_q == IDLE_LAST) && !any_edge;

    always_comb begin
        run_d     = run_q;
        hi_hold_d = hi_hold_q;
        idle_d    = idle_q;
        if (any_edge) begin
            run_d = CNT_W'(1);
        end else if (run_q != '1) begin
            run_d = run_q + CNT_W'(1);
        end
        if (fall) begin
            hi_hold_d = run_q;
        end
        if (any_edge) begin
            idle_d = '0;
        end else if (!expire) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        high_buf_d = high_buf_q;
        low_buf_d  = low_buf_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        if (any_edge) begin
            timeout_d = 1'b0;
        end
        case (state_q)
            WAIT_RISE: if (rise) state_d = MEAS_HIGH;
            MEAS_HIGH: if (fall) state_d = MEAS_LOW;
            MEAS_LOW: begin
                if (rise) begin
                    state_d    = MEAS_HIGH;
                    high_buf_d = hi_hold_q;
                    low_buf_d  = run_q;
                    valid_d    = 1'b1;
                end
            end
            default: state_d = WAIT_RISE;
        endcase
        if (expire) begin
            state_d    = WAIT_RISE;
            high_buf_d = '0;
            low_buf_d  = '0;
            timeout_d  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= WAIT_RISE;
            run_q      <= '0;
            hi_hold_q  <= '0;
            high_buf_q <= '0;
            low_buf_q  <= '0;
            idle_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            hi_hold_q  <= hi_hold_d;
            high_buf_q <= high_buf_d;
            low_buf_q  <= low_buf_d;
            idle_q     <= idle_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.sig_in_high_cnt_buf = high_buf_q;
    assign bus.sig_in_low_cnt_buf  = low_buf_q;
    assign bus.meas_valid          = valid_q;
    assign bus.sig_timeout         = timeout_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Drives one random/directed square wave into a 32-bit and a 4-bit meter and
// compares every cycle against a run-length model of the input waveform.
module tb_duty_cycle_meter;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 100;

    logic sys_clk;
    logic rst_n;

    duty_cycle_meter_if #(.CNT_W(32)) ifw ();
    duty_cycle_meter_if #(.CNT_W(4))  ifn ();

    duty_cycle_meter #(
        .CNT_W(32),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut_w (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus    (ifw)
    );

    duty_cycle_meter #(
        .CNT_W(4),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut_n (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus    (ifn)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned pulses   = 0;

    // Model: hist[i] is the level sampled at posedge i after reset release.
    bit          hist[$];
    int unsigned n;
    int unsigned e_last;
    int unsigned epoch_edges;
    int unsigned rise_t;
    int unsigned fall_t;
    logic [31:0] exp_hi[2];
    logic [31:0] exp_lo[2];
    bit          exp_valid;
    bit          exp_tmo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit lvl(input int i);
        if (i < 1 || i >= int'(hist.size())) return 1'b0;
        return hist[i];
    endfunction

    function automatic logic [31:0] sat(input int unsigned x, input int k);
        logic [31:0] mx;
        mx = (k == 1) ? 32'd15 : 32'hFFFF_FFFF;
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_init();
        hist.delete();
        hist.push_back(1'b0);
        n = 0; e_last = 0; epoch_edges = 0; rise_t = 0; fall_t = 0;
        exp_valid = 1'b0; exp_tmo = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_hi[k] = '0;
            exp_lo[k] = '0;
        end
    endtask

    // A level change in the waveform takes effect SYNC cycles after it is sampled.
    task automatic model_step();
        int cur;
        bit a, b;
        cur = int'(n) - int'(SYNC);
        a = lvl(cur);
        b = lvl(cur - 1);
        exp_valid = 1'b0;
        if (a != b) begin
            exp_tmo = 1'b0;
            if (a) begin
                if (epoch_edges >= 2) begin
                    exp_valid = 1'b1;
                    for (int k = 0; k < 2; k++) begin
                        exp_hi[k] = sat(fall_t - rise_t, k);
                        exp_lo[k] = sat(n - fall_t, k);
                    end
                end
                rise_t = n;
            end else begin
                fall_t = n;
            end
            epoch_edges++;
            e_last = n;
        end else if (n - e_last >= TMO) begin
            exp_tmo     = 1'b1;
            epoch_edges = 0;
            for (int k = 0; k < 2; k++) begin
                exp_hi[k] = '0;
                exp_lo[k] = '0;
            end
        end
    endtask

    // Called at a negedge; drives one sample, checks after the posedge, returns at the next negedge.
    task automatic tick(input bit v);
        ifw.sig_in = v;
        ifn.sig_in = v;
        hist.push_back(v);
        @(posedge sys_clk);
        n++;
        model_step();
        #1;
        if (ifw.meas_valid) pulses++;
        check("valid_w", 32'(ifw.meas_valid), 32'(exp_valid));
        check("high_w",  ifw.sig_in_high_cnt_buf, exp_hi[0]);
        check("low_w",   ifw.sig_in_low_cnt_buf,  exp_lo[0]);
        check("tmo_w",   32'(ifw.sig_timeout), 32'(exp_tmo));
        check("valid_n", 32'(ifn.meas_valid), 32'(exp_valid));
        check("high_n",  32'(ifn.sig_in_high_cnt_buf), exp_hi[1]);
        check("low_n",   32'(ifn.sig_in_low_cnt_buf),  exp_lo[1]);
        check("tmo_n",   32'(ifn.sig_timeout), 32'(exp_tmo));
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b1;
        #1;
        check("rst_high_w",  ifw.sig_in_high_cnt_buf, 32'd0);
        check("rst_low_w",   ifw.sig_in_low_cnt_buf,  32'd0);
        check("rst_valid_w", 32'(ifw.meas_valid), 32'd0);
        check("rst_tmo_w",   32'(ifw.sig_timeout), 32'd0);
        check("rst_high_n",  32'(ifn.sig_in_high_cnt_buf), 32'd0);
        check("rst_low_n",   32'(ifn.sig_in_low_cnt_buf),  32'd0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b0;
        model_init();
    endtask

    task automatic wave(input int unsigned h, input int unsigned l, input int unsigned periods);
        for (int unsigned p = 0; p < periods; p++) begin
            for (int unsigned i = 0; i < h; i++) tick(1'b1);
            for (int unsigned i = 0; i < l; i++) tick(1'b0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ifw.sig_in = 1'b0;
        ifn.sig_in = 1'b0;
        model_init();
        do_reset();

        // 3 high / 5 low: first publish after rise, fall, rise
        tick(1'b0); tick(1'b0);
        pulses = 0;
        wave(3, 5, 10);
        check("pulses_3_5", pulses, 32'd9);
        check("dir_high_3", ifw.sig_in_high_cnt_buf, 32'd3);
        check("dir_low_5",  ifw.sig_in_low_cnt_buf,  32'd5);

        wave(6, 2, 5);
        check("dir_high_6", ifw.sig_in_high_cnt_buf, 32'd6);
        check("dir_low_2",  ifw.sig_in_low_cnt_buf,  32'd2);

        wave(1, 3, 8);
        check("dir_high_1", ifw.sig_in_high_cnt_buf, 32'd1);
        check("dir_low_3",  ifw.sig_in_low_cnt_buf,  32'd3);

        wave(20, 5, 3);
        check("dir_sat_n",  32'(ifn.sig_in_high_cnt_buf), 32'd15);
        check("dir_high_w", ifw.sig_in_high_cnt_buf, 32'd20);

        // Reset while in the low phase
        wave(4, 4, 3);
        wave(4, 0, 1);
        tick(1'b0); tick(1'b0); tick(1'b0);
        do_reset();
        pulses = 0;
        wave(4, 4, 1);
        check("no_valid_after_rst", pulses, 32'd0);
        wave(4, 4, 3);

        // Idle low from reset: timeout exactly at cycle TMO
        do_reset();
        for (int unsigned i = 1; i < TMO; i++) tick(1'b0);
        check("tmo_before", 32'(ifw.sig_timeout), 32'd0);
        tick(1'b0);
        check("tmo_at", 32'(ifw.sig_timeout), 32'd1);
        tick(1'b0);
        tick(1'b1); tick(1'b1); tick(1'b1);
        check("tmo_clear", 32'(ifw.sig_timeout), 32'd0);
        wave(2, 3, 4);

        // Timeout after measuring, then low runs at the expiry boundary
        wave(3, 5, 3);
        for (int unsigned i = 0; i < 120; i++) tick(1'b0);
        check("tmo_buf_zero", ifw.sig_in_high_cnt_buf, 32'd0);
        wave(3, 100, 2);
        wave(3, 101, 2);
        wave(130, 4, 1);
        wave(5, 7, 3);

        for (int unsigned p = 0; p < 40; p++) begin
            int unsigned h, l;
            h = $urandom_range(1, 22);
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(95, 105) : $urandom_range(1, 22);
            wave(h, l, 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
